wire_ops_pipe: RTL and testbench
================================

Name: wire_ops_pipe

Overview:
Parametrised successor to the single-register logic-op block. It is a WIDTH-bit, multi-op ALU slice with a valid/ready handshake and a STAGES-deep elastic pipeline. Per-stage stall propagation lets it sit between streaming producers and consumers without data loss. A result counter gives lightweight throughput visibility.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
STAGES, 2, pipeline depth = latency in cycles (1..4)
CNT_W, 16, width of completed-result counter

Ports:
sys_clk  input  1  clock, all state on rising edge
sys_rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush of all in-flight results
in_valid  input  1  operand beat offered
in_ready  output  1  block accepts beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select (see Behaviour)
out_valid  output  1  result beat offered
out_ready  input  1  consumer accepts result
y  output  WIDTH  result
zero  output  1  y == 0
carry  output  1  carry-out (ADD) / no-borrow (SUB), 0 otherwise
done_cnt  output  CNT_W  count of results handed off (out_valid & out_ready)

Behaviour:
- Reset (sys_rst_n low, async): all stage valid bits 0, stage data/flags 0, done_cnt 0. Outputs: out_valid 0, y 0, zero 0, carry 0, done_cnt 0. in_ready is combinational and reads 1 after reset unless clr is high.
- Ops, evaluated combinationally before stage 1:
  - 0 AND, 1 OR, 2 XOR.
  - 3 ADD: carry = bit WIDTH of a+b.
  - 4 SUB: y = a-b mod 2^WIDTH; carry = (a >= b) unsigned.
  - 5 NOT a, 6 PASS a, 7 MUX: y = b[0] ? a : ~a.
  - carry is 0 for all ops except 3 and 4.
- zero is computed from the WIDTH-bit result and carried alongside it.
- Stage k (1..STAGES) holds {valid_k, y_k, zero_k, carry_k}. Stage STAGES drives the outputs directly. No combinational path from a/b/op to y.
- Advance rule:
  - adv_STAGES = !valid_STAGES | out_ready.
  - adv_k = !valid_k | adv_{k+1}.
  - in_ready = adv_1 & !clr.
  - On adv_k, stage k loads from stage k-1 (stage 0 = {in_valid & in_ready, op result}).
  - Otherwise stage k holds.
  - This gives full throughput (1 beat/cycle) when out_ready is held high. Bubbles compress under backpressure.
- Latency: a beat accepted in cycle t appears with out_valid in cycle t+STAGES if there are no stalls.
- Handshake: once out_valid is high, y/zero/carry stay stable until out_ready is sampled high. out_valid never drops without a handshake, except on clr or reset.
- Data in stages whose valid bit is 0 is don't-care. The implementation may hold or update it.
- clr (sync): next cycle all valid bits are 0, and the beat presented with clr is not accepted (in_ready 0).
  - If out_valid & out_ready & clr coincide, that handoff completes and done_cnt increments.
  - done_cnt is not cleared by clr.
- done_cnt increments by 1 per out_valid & out_ready and wraps 2^CNT_W-1 -> 0.
- Reset mid-stream: all in-flight beats are discarded immediately. No partial beat is emitted after reset release.

Test Plan:
- Reset, WIDTH=8, STAGES=2: after sys_rst_n released, out_valid=0, y=0, done_cnt=0, in_ready=1.
- Op sweep, out_ready=1, streamed back-to-back:
  - a=0xC3, b=0x5A: AND->0x42, OR->0xDB, XOR->0x99.
  - NOT->0x3C, PASS->0xC3.
  - MUX with b[0]=0 -> 0x3C.
  - Each result appears exactly 2 cycles after acceptance, one per cycle.
- Arithmetic flags:
  - ADD 0xFF+0x01 -> y=0x00, zero=1, carry=1.
  - SUB 0x10-0x20 -> y=0xF0, carry=0.
  - SUB 0x20-0x20 -> y=0x00, zero=1, carry=1.
- Backpressure:
  - Stream 5 beats with out_ready=0. Only STAGES=2 beats are accepted and in_ready drops.
  - Raise out_ready: all 5 results emerge in order, with none lost or duplicated.
  - y stays stable while stalled. done_cnt=5.
- Flush:
  - With 2 beats in flight and out_ready=0, pulse clr with in_valid=1. The next cycle out_valid=0, that beat is not accepted, and done_cnt is unchanged.
  - Repeat with out_ready=1 on the clr cycle: done_cnt +1.
- Counter wrap: CNT_W=4, 17 handshakes -> done_cnt=1. Async reset asserted mid-stream -> out_valid falls without waiting for a clock edge.

Source files
------------

// File: rtl/wire_ops_pipe_if.sv
// Handshake and data bundle for the wire_ops_pipe ALU slice: operand stream in,
// result stream out, plus the completed-result counter.
interface wire_ops_pipe_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             zero;
   logic             carry;
   logic [CNT_W-1:0] done_cnt;

   // The pipeline itself: consumes operands and offers results.
   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, y, zero, carry, done_cnt
   );

   // Whatever drives operands and consumes results around the pipeline.
   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, y, zero, carry, done_cnt
   );
endinterface

// File: rtl/wire_ops_pipe.sv
// WIDTH-bit multi-op ALU slice behind a STAGES-deep elastic valid/ready pipeline.
// Each stage advances whenever any stage downstream of it has room, so bubbles
// squeeze out under backpressure and a full pipe still moves one beat per cycle.
module wire_ops_pipe #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              clr,
   wire_ops_pipe_if.slave    bus
);

   logic [WIDTH:0]   sumWide;
   logic [WIDTH:0]   diffWide;
   logic [WIDTH-1:0] opY;
   logic             opZero;
   logic             opCarry;

   logic [STAGES-1:0] stageAdv;
   logic              advRun;
   logic              inReady;
   logic              accept;
   logic              handoff;

   logic [STAGES-1:0] stageVld_q;
   logic [STAGES-1:0] stageVld_d;
   logic [WIDTH-1:0]  stageY_q [STAGES];
   logic [WIDTH-1:0]  stageY_d [STAGES];
   logic [STAGES-1:0] stageZero_q;
   logic [STAGES-1:0] stageZero_d;
   logic [STAGES-1:0] stageCarry_q;
   logic [STAGES-1:0] stageCarry_d;
   logic [CNT_W-1:0]  doneCnt_q;
   logic [CNT_W-1:0]  doneCnt_d;

   // Operation result and flags, formed from the raw operands ahead of stage 1.
   always_comb begin
      sumWide  = {1'b0, bus.a} + {1'b0, bus.b};
      diffWide = {1'b0, bus.a} - {1'b0, bus.b};
      opY      = '0;
      opCarry  = 1'b0;
      case (bus.op)
         3'd0: opY = bus.a & bus.b;
         3'd1: opY = bus.a | bus.b;
         3'd2: opY = bus.a ^ bus.b;
         3'd3: begin
            opY     = sumWide[WIDTH-1:0];
            opCarry = sumWide[WIDTH];
         end
         3'd4: begin
            opY     = diffWide[WIDTH-1:0];
            opCarry = ~diffWide[WIDTH];
         end
         3'd5: opY = ~bus.a;
         3'd6: opY = bus.a;
         3'd7: opY = bus.b[0] ? bus.a : ~bus.a;
      endcase
      opZero = (opY == '0);
   end

   // Stage k may advance if out_ready is high or any stage at or beyond k is
   // empty; walking from the output backwards accumulates that condition.
   always_comb begin
      advRun   = bus.out_ready;
      stageAdv = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         advRun      = advRun | ~stageVld_q[k];
         stageAdv[k] = advRun;
      end
   end

   assign inReady = stageAdv[0] & ~clr;
   assign accept  = bus.in_valid & inReady;
   assign handoff = stageVld_q[STAGES-1] & bus.out_ready;

   // Next-state of each stage: load from the stage behind when advancing, hold
   // otherwise; clr empties every stage but leaves the data alone.
   always_comb begin
      stageVld_d   = stageVld_q;
      stageY_d     = stageY_q;
      stageZero_d  = stageZero_q;
      stageCarry_d = stageCarry_q;
      if (stageAdv[0]) begin
         stageVld_d[0]   = accept;
         stageY_d[0]     = opY;
         stageZero_d[0]  = opZero;
         stageCarry_d[0] = opCarry;
      end
      for (int k = 1; k < STAGES; k++) begin
         if (stageAdv[k]) begin
            stageVld_d[k]   = stageVld_q[k-1];
            stageY_d[k]     = stageY_q[k-1];
            stageZero_d[k]  = stageZero_q[k-1];
            stageCarry_d[k] = stageCarry_q[k-1];
         end
      end
      if (clr) begin
         stageVld_d = '0;
      end
      doneCnt_d = doneCnt_q + CNT_W'(handoff);
   end

   // Pipeline and counter registers; reset discards everything in flight at once.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         stageVld_q   <= '0;
         stageZero_q  <= '0;
         stageCarry_q <= '0;
         doneCnt_q    <= '0;
         for (int k = 0; k < STAGES; k++) begin
            stageY_q[k] <= '0;
         end
      end else begin
         stageVld_q   <= stageVld_d;
         stageY_q     <= stageY_d;
         stageZero_q  <= stageZero_d;
         stageCarry_q <= stageCarry_d;
         doneCnt_q    <= doneCnt_d;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = stageVld_q[STAGES-1];
   assign bus.y         = stageY_q[STAGES-1];
   assign bus.zero      = stageZero_q[STAGES-1];
   assign bus.carry     = stageCarry_q[STAGES-1];
   assign bus.done_cnt  = doneCnt_q;

endmodule

// File: tb/tb_wire_ops_pipe.sv
// Bench for wire_ops_pipe: directed and random traffic checked every cycle
// against a queue-of-beats model of an elastic pipe with fixed minimum latency.
module tb_wire_ops_pipe;

   localparam int WIDTH  = 8;
   localparam int STAGES = 2;
   localparam int CNT_W  = 4;
   localparam int CNT_MOD = 1 << CNT_W;

   logic sysClk;
   logic sysRstN;
   logic clr;

   wire_ops_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   wire_ops_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .sys_clk   (sysClk),
      .sys_rst_n (sysRstN),
      .clr       (clr),
      .bus       (bus.slave)
   );

   typedef struct {
      logic [7:0] y;
      logic       z;
      logic       c;
      int         readyAt;
   } beat_t;

   beat_t modelQ[$];
   int    modelDone;
   int    cyc;
   int    testsRun;
   int    testsFailed;
   bit    lastAccepted;

   // Free-running clock.
   initial begin
      sysClk = 1'b0;
      forever #5 sysClk = ~sysClk;
   end

   // Reference result computed straight from the operation definitions.
   function automatic beat_t refOp(int a, int b, int op);
      beat_t r;
      int    res;
      r.c = 1'b0;
      res = 0;
      case (op)
         0: res = a & b;
         1: res = a | b;
         2: res = a ^ b;
         3: begin
            res = (a + b) % 256;
            r.c = ((a + b) > 255);
         end
         4: begin
            res = (a - b + 256) % 256;
            r.c = (a >= b);
         end
         5: res = 255 - a;
         6: res = a;
         default: res = (b % 2 == 1) ? a : 255 - a;
      endcase
      r.y       = res[7:0];
      r.z       = (res == 0);
      r.readyAt = 0;
      return r;
   endfunction

   task automatic checkEq(string tag, logic [31:0] obs, logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic applyStimulus(bit inV, int a, int b, int op, bit outR, bit clrV);
      bus.in_valid  = inV;
      bus.a         = a[7:0];
      bus.b         = b[7:0];
      bus.op        = op[2:0];
      bus.out_ready = outR;
      clr           = clrV;
   endtask

   // Compare DUT outputs against the model for the current cycle.
   task automatic checkOutput();
      bit expIn;
      bit expOut;
      expIn  = !clr && (modelQ.size() < STAGES || bus.out_ready);
      expOut = (modelQ.size() > 0) && (cyc >= modelQ[0].readyAt);
      checkEq("in_ready", {31'd0, bus.in_ready}, {31'd0, expIn});
      checkEq("out_valid", {31'd0, bus.out_valid}, {31'd0, expOut});
      checkEq("done_cnt", 32'(bus.done_cnt), 32'(modelDone));
      if (expOut) begin
         checkEq("y", 32'(bus.y), 32'(modelQ[0].y));
         checkEq("zero", {31'd0, bus.zero}, {31'd0, modelQ[0].z});
         checkEq("carry", {31'd0, bus.carry}, {31'd0, modelQ[0].c});
      end
   endtask

   // One clock cycle: check, advance the model across the edge, step the clock.
   task automatic tick();
      bit    expIn;
      bit    expOut;
      beat_t nb;
      #1;
      checkOutput();
      expIn  = !clr && (modelQ.size() < STAGES || bus.out_ready);
      expOut = (modelQ.size() > 0) && (cyc >= modelQ[0].readyAt);
      lastAccepted = 1'b0;
      if (expOut && bus.out_ready) begin
         void'(modelQ.pop_front());
         modelDone = (modelDone + 1) % CNT_MOD;
         if (modelQ.size() > 0 && modelQ[0].readyAt < cyc + 1) begin
            modelQ[0].readyAt = cyc + 1;
         end
      end
      if (clr) begin
         modelQ.delete();
      end else if (bus.in_valid && expIn) begin
         nb = refOp(int'(bus.a), int'(bus.b), int'(bus.op));
         nb.readyAt = cyc + STAGES;
         modelQ.push_back(nb);
         lastAccepted = 1'b1;
      end
      @(posedge sysClk);
      cyc++;
      @(negedge sysClk);
   endtask

   task automatic drainAll(bit outR);
      for (int i = 0; i < 40 && modelQ.size() > 0; i++) begin
         applyStimulus(1'b0, 0, 0, 0, outR, 1'b0);
         tick();
      end
      checkEq("drain_empty", 32'(modelQ.size()), 32'd0);
   endtask

   int sweepOps[6] = '{0, 1, 2, 5, 6, 7};
   int bpA[5];
   int bpB[5];
   int bpOp[5];

   initial begin
      int idx;
      testsRun    = 0;
      testsFailed = 0;
      modelDone   = 0;
      cyc         = 0;
      sysRstN     = 1'b0;
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);

      // Reset and release.
      repeat (2) @(negedge sysClk);
      sysRstN = 1'b1;
      #1;
      checkEq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkEq("rst_y", 32'(bus.y), 32'd0);
      checkEq("rst_zero", {31'd0, bus.zero}, 32'd0);
      checkEq("rst_carry", {31'd0, bus.carry}, 32'd0);
      checkEq("rst_done", 32'(bus.done_cnt), 32'd0);
      checkEq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();

      // Logic op sweep, back-to-back with the consumer always ready.
      foreach (sweepOps[i]) begin
         applyStimulus(1'b1, 'hC3, 'h5A, sweepOps[i], 1'b1, 1'b0);
         tick();
      end
      // Arithmetic corner cases.
      applyStimulus(1'b1, 'hFF, 'h01, 3, 1'b1, 1'b0); tick();
      applyStimulus(1'b1, 'h10, 'h20, 4, 1'b1, 1'b0); tick();
      applyStimulus(1'b1, 'h20, 'h20, 4, 1'b1, 1'b0); tick();
      drainAll(1'b1);

      // Backpressure: five beats offered against a stalled consumer.
      for (int i = 0; i < 5; i++) begin
         bpA[i]  = int'($urandom_range(0, 255));
         bpB[i]  = int'($urandom_range(0, 255));
         bpOp[i] = int'($urandom_range(0, 7));
      end
      begin
         int baseDone;
         baseDone = modelDone;
         idx = 0;
         for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, bpA[idx], bpB[idx], bpOp[idx], 1'b0, 1'b0);
            tick();
            if (lastAccepted) idx++;
         end
         for (int i = 0; i < 30 && (idx < 5 || modelQ.size() > 0); i++) begin
            if (idx < 5) applyStimulus(1'b1, bpA[idx], bpB[idx], bpOp[idx], 1'b1, 1'b0);
            else         applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
            tick();
            if (lastAccepted) idx++;
         end
         checkEq("bp_all_accepted", 32'(idx), 32'd5);
         checkEq("bp_done", 32'(bus.done_cnt), 32'((baseDone + 5) % CNT_MOD));
      end

      // Flush with the consumer stalled, then with a coincident handoff.
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 10 && modelQ.size() < 2; i++) begin
            applyStimulus(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 7)), 1'b0, 1'b0);
            tick();
         end
         applyStimulus(1'b1, 'hAA, 'h55, 3, pass[0], 1'b1);
         tick();
         applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
         tick();
         tick();
      end

      // Random traffic with occasional flushes.
      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         tick();
      end
      drainAll(1'b1);

      // Asynchronous reset in the middle of a stream.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 7)), 1'b1, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
      sysRstN = 1'b0;
      #1;
      checkEq("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkEq("async_rst_y", 32'(bus.y), 32'd0);
      checkEq("async_rst_done", 32'(bus.done_cnt), 32'd0);
      modelQ.delete();
      modelDone = 0;
      repeat (2) begin
         @(posedge sysClk);
         cyc++;
         @(negedge sysClk);
      end
      sysRstN = 1'b1;
      repeat (3) tick();

      // Counter wrap: seventeen handoffs on a four-bit counter.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 7)), 1'b1, 1'b0);
         tick();
      end
      drainAll(1'b1);
      checkEq("wrap_done", 32'(bus.done_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
